// File: rtl/opto_emit_scheduler_if.sv
// Bus bundle between the scan sequencer and its surroundings: encoder/zero
// index, emission-period generator, TDC front end and laser drivers.
//   master : drives scan control, window, sync ticks and TDC ack; observes results
//   slave  : the scheduler; drives ready, TDC arm, fire pulses and status
interface opto_emit_scheduler_if #(
  parameter int unsigned CH_NUM = 4,
  parameter int unsigned CH_W   = 2
);
  logic              i_scan_en;
  logic [CH_NUM-1:0] i_ch_mask;
  logic [15:0]       i_start_idx;
  logic [15:0]       i_stop_idx;
  logic              i_zero_sync;
  logic              i_tdc_strdy;
  logic              i_angle_sync;
  logic              i_tdc_ack;
  logic              o_sync_ready;
  logic              o_tdc_arm;
  logic [CH_NUM-1:0] o_laser_fire;
  logic [CH_W-1:0]   o_fire_ch;
  logic [15:0]       o_fire_idx;
  logic [15:0]       o_miss_cnt;

  modport master (
    output i_scan_en, i_ch_mask, i_start_idx, i_stop_idx,
           i_zero_sync, i_tdc_strdy, i_angle_sync, i_tdc_ack,
    input  o_sync_ready, o_tdc_arm, o_laser_fire, o_fire_ch, o_fire_idx, o_miss_cnt
  );

  modport slave (
    input  i_scan_en, i_ch_mask, i_start_idx, i_stop_idx,
           i_zero_sync, i_tdc_strdy, i_angle_sync, i_tdc_ack,
    output o_sync_ready, o_tdc_arm, o_laser_fire, o_fire_ch, o_fire_idx, o_miss_cnt
  );
endinterface

// File: rtl/opto_emit_scheduler.sv
// Laser emission scheduler for the rotating-mirror scan. Arms the TDC on the
// pre-fire tick, fires one round-robin channel per angle tick inside the
// programmed shot-index window, and counts shots lost to a late TDC ack.
// Ports:
//   i_clk, i_rst_n : clock, asynchronous active-low reset
//   bus (slave)    : scan control, window, sync ticks, TDC handshake, fire outputs
module opto_emit_scheduler #(
  parameter int unsigned CH_NUM      = 4,
  parameter int unsigned PULSE_W_CLK = 5,
  parameter int unsigned CH_W        = 2
) (
  input logic                  i_clk,
  input logic                  i_rst_n,
  opto_emit_scheduler_if.slave bus
);

  localparam int unsigned CNT_W   = 6;
  localparam int unsigned IDX_W   = 16;
  localparam logic [IDX_W-1:0] IDX_MAX = '1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_ZERO,
    ST_RUN,
    ST_WAIT_ACK,
    ST_WAIT_SYNC,
    ST_FIRE
  } state_e;

  state_e            state_q, state_d;
  logic [IDX_W-1:0]  shot_idx_q, shot_idx_d;
  logic [CH_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]   ch_q, ch_d;
  logic [CNT_W-1:0]  pulse_cnt_q, pulse_cnt_d;
  logic              sync_ready_q, sync_ready_d;
  logic              tdc_arm_q, tdc_arm_d;
  logic [CH_NUM-1:0] laser_fire_q, laser_fire_d;
  logic [CH_W-1:0]   fire_ch_q, fire_ch_d;
  logic [IDX_W-1:0]  fire_idx_q, fire_idx_d;
  logic [IDX_W-1:0]  miss_cnt_q, miss_cnt_d;

  logic [CH_W-1:0]   next_ch_c;
  logic              window_open_c;

  // Round-robin pick: first enabled channel after rr_ptr, wrapping. Scanning
  // from the farthest candidate down leaves the nearest one as the winner.
  always_comb begin
    next_ch_c = rr_ptr_q;
    for (int k = int'(CH_NUM); k >= 1; k--) begin
      if (bus.i_ch_mask[CH_W'((int'(rr_ptr_q) + k) % int'(CH_NUM))]) begin
        next_ch_c = CH_W'((int'(rr_ptr_q) + k) % int'(CH_NUM));
      end
    end
  end

  // An inverted window (start > stop) can never satisfy both bounds.
  assign window_open_c = (bus.i_start_idx <= shot_idx_q) && (shot_idx_q <= bus.i_stop_idx);

  // Next-state and output logic.
  always_comb begin
    state_d      = state_q;
    shot_idx_d   = shot_idx_q;
    rr_ptr_d     = rr_ptr_q;
    ch_d         = ch_q;
    pulse_cnt_d  = pulse_cnt_q;
    sync_ready_d = sync_ready_q;
    tdc_arm_d    = tdc_arm_q;
    laser_fire_d = laser_fire_q;
    fire_ch_d    = fire_ch_q;
    fire_idx_d   = fire_idx_q;
    miss_cnt_d   = miss_cnt_q;

    // Shot index follows the encoder in every active state; zero beats angle.
    if (state_q != ST_IDLE) begin
      if (bus.i_zero_sync) begin
        shot_idx_d = '0;
      end else if (bus.i_angle_sync && (shot_idx_q != IDX_MAX)) begin
        shot_idx_d = shot_idx_q + 16'd1;
      end
    end

    case (state_q)
      ST_IDLE: begin
        sync_ready_d = 1'b0;
        tdc_arm_d    = 1'b0;
        laser_fire_d = '0;
        if (bus.i_scan_en) state_d = ST_WAIT_ZERO;
      end
      ST_WAIT_ZERO: begin
        if (bus.i_zero_sync) begin
          sync_ready_d = 1'b1;
          state_d      = ST_RUN;
        end
      end
      ST_RUN: begin
        if (bus.i_tdc_strdy && window_open_c && (bus.i_ch_mask != '0)) begin
          ch_d      = next_ch_c;
          tdc_arm_d = 1'b1;
          state_d   = ST_WAIT_ACK;
        end
      end
      ST_WAIT_ACK: begin
        // Emission tick before the ack loses the shot; rr_ptr stays so the
        // same channel is retried on the next shot.
        if (bus.i_angle_sync) begin
          tdc_arm_d = 1'b0;
          if (miss_cnt_q != IDX_MAX) miss_cnt_d = miss_cnt_q + 16'd1;
          state_d = ST_RUN;
        end else if (bus.i_tdc_ack) begin
          tdc_arm_d = 1'b0;
          state_d   = ST_WAIT_SYNC;
        end
      end
      ST_WAIT_SYNC: begin
        if (bus.i_angle_sync) begin
          laser_fire_d       = '0;
          laser_fire_d[ch_q] = 1'b1;
          fire_ch_d          = ch_q;
          fire_idx_d         = shot_idx_q;
          rr_ptr_d           = ch_q;
          pulse_cnt_d        = CNT_W'(PULSE_W_CLK - 1);
          state_d            = ST_FIRE;
        end
      end
      ST_FIRE: begin
        if (pulse_cnt_q == '0) begin
          laser_fire_d = '0;
          state_d      = ST_RUN;
        end else begin
          pulse_cnt_d = pulse_cnt_q - CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Scan disable aborts from anywhere, truncating any pulse in flight.
    if (!bus.i_scan_en) begin
      state_d      = ST_IDLE;
      sync_ready_d = 1'b0;
      tdc_arm_d    = 1'b0;
      laser_fire_d = '0;
    end
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= ST_IDLE;
      shot_idx_q   <= '0;
      rr_ptr_q     <= CH_W'(CH_NUM - 1);
      ch_q         <= '0;
      pulse_cnt_q  <= '0;
      sync_ready_q <= 1'b0;
      tdc_arm_q    <= 1'b0;
      laser_fire_q <= '0;
      fire_ch_q    <= '0;
      fire_idx_q   <= '0;
      miss_cnt_q   <= '0;
    end else begin
      state_q      <= state_d;
      shot_idx_q   <= shot_idx_d;
      rr_ptr_q     <= rr_ptr_d;
      ch_q         <= ch_d;
      pulse_cnt_q  <= pulse_cnt_d;
      sync_ready_q <= sync_ready_d;
      tdc_arm_q    <= tdc_arm_d;
      laser_fire_q <= laser_fire_d;
      fire_ch_q    <= fire_ch_d;
      fire_idx_q   <= fire_idx_d;
      miss_cnt_q   <= miss_cnt_d;
    end
  end

  assign bus.o_sync_ready = sync_ready_q;
  assign bus.o_tdc_arm    = tdc_arm_q;
  assign bus.o_laser_fire = laser_fire_q;
  assign bus.o_fire_ch    = fire_ch_q;
  assign bus.o_fire_idx   = fire_idx_q;
  assign bus.o_miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_opto_emit_scheduler.sv
// Self-checking bench for opto_emit_scheduler. Each emission period is a fixed
// PER-clock timeline (strdy at 0, angle at ANG); a shot-level model predicts
// arm/fire/ready per cycle and the status outputs after each period.
module tb_opto_emit_scheduler;

  localparam int unsigned CH_NUM = 4;
  localparam int unsigned PW     = 5;
  localparam int unsigned CH_W   = 2;
  localparam int          PER    = 30;
  localparam int          ANG    = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  opto_emit_scheduler_if #(.CH_NUM(CH_NUM), .CH_W(CH_W)) bus ();

  opto_emit_scheduler #(.CH_NUM(CH_NUM), .PULSE_W_CLK(PW), .CH_W(CH_W)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int checks   = 0;
  int failures = 0;

  // Shot-level model state
  int m_idx, m_rr, m_miss, m_last_ch, m_last_idx;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_idx = 0; m_rr = CH_NUM - 1; m_miss = 0; m_last_ch = 0; m_last_idx = 0;
  endtask

  // Ordered list of enabled channels; take the first above the last fired one.
  function automatic int pick(input int rr, input logic [CH_NUM-1:0] m);
    int q[$];
    for (int i = 0; i < int'(CH_NUM); i++) if (m[i]) q.push_back(i);
    foreach (q[j]) if (q[j] > rr) return q[j];
    return q[0];
  endfunction

  task automatic set_cfg(input logic [CH_NUM-1:0] mask, input int start, input int stop);
    bus.i_ch_mask   = mask;
    bus.i_start_idx = 16'(start);
    bus.i_stop_idx  = 16'(stop);
  endtask

  task automatic stop_scan();
    bus.i_scan_en = 1'b0;
    tick();
    tick();
  endtask

  task automatic start_scan();
    bus.i_scan_en = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.o_sync_ready !== 1'b0) begin
      failures++; $display("FAIL ready_before_zero got=%b exp=0", bus.o_sync_ready);
    end
    bus.i_zero_sync = 1'b1;
    tick();
    bus.i_zero_sync = 1'b0;
    checks++;
    if (bus.o_sync_ready !== 1'b1) begin
      failures++; $display("FAIL ready_after_zero got=%b exp=1", bus.o_sync_ready);
    end
    m_idx = 0;
  endtask

  // One emission period. ack_cyc / zero_cyc / abort_cyc: cycle of that event, -1 for none.
  task automatic run_period(input int ack_cyc, input int zero_cyc, input int abort_cyc,
                            output bit obs_fired);
    bit win, armed, acked, fired, eff, alive;
    int ch, cy;
    logic [CH_NUM-1:0] onehot, exp_fire;
    logic exp_arm, exp_ready;
    win   = (int'(bus.i_start_idx) <= m_idx) && (m_idx <= int'(bus.i_stop_idx));
    armed = win && (bus.i_ch_mask != '0);
    ch    = armed ? pick(m_rr, bus.i_ch_mask) : 0;
    eff   = (abort_cyc < 0) || (abort_cyc > ANG);
    acked = armed && (ack_cyc >= 1) && (ack_cyc < ANG);
    fired = acked && eff;
    onehot = '0;
    if (fired) onehot[ch] = 1'b1;
    obs_fired = 1'b0;
    for (int c = 0; c < PER; c++) begin
      bus.i_tdc_strdy  = (c == 0);
      bus.i_angle_sync = (c == ANG);
      bus.i_tdc_ack    = (c == ack_cyc);
      bus.i_zero_sync  = (c == zero_cyc);
      if (c == abort_cyc) bus.i_scan_en = 1'b0;
      tick();
      cy        = c + 1;
      alive     = (abort_cyc < 0) || (cy <= abort_cyc);
      exp_arm   = alive && armed && (cy <= (acked ? ack_cyc : ANG));
      exp_fire  = (alive && fired && cy > ANG && cy <= ANG + int'(PW)) ? onehot : '0;
      exp_ready = alive;
      checks++;
      if (bus.o_tdc_arm !== exp_arm) begin
        failures++; $display("FAIL arm idx=%0d cyc=%0d got=%b exp=%b", m_idx, cy, bus.o_tdc_arm, exp_arm);
      end
      checks++;
      if (bus.o_laser_fire !== exp_fire) begin
        failures++; $display("FAIL fire idx=%0d cyc=%0d got=%b exp=%b", m_idx, cy, bus.o_laser_fire, exp_fire);
      end
      checks++;
      if (bus.o_sync_ready !== exp_ready) begin
        failures++; $display("FAIL ready idx=%0d cyc=%0d got=%b exp=%b", m_idx, cy, bus.o_sync_ready, exp_ready);
      end
      if (bus.o_laser_fire != '0) obs_fired = 1'b1;
    end
    bus.i_tdc_strdy = 1'b0; bus.i_angle_sync = 1'b0; bus.i_tdc_ack = 1'b0; bus.i_zero_sync = 1'b0;
    if (eff && armed && !fired && m_miss < 65535) m_miss++;
    if (fired) begin
      m_last_ch = ch; m_last_idx = m_idx; m_rr = ch;
    end
    if (zero_cyc >= ANG) m_idx = 0;
    else if (m_idx < 65535) m_idx++;
    checks++;
    if (bus.o_fire_ch !== CH_W'(m_last_ch)) begin
      failures++; $display("FAIL fire_ch got=%0d exp=%0d", bus.o_fire_ch, m_last_ch);
    end
    checks++;
    if (bus.o_fire_idx !== 16'(m_last_idx)) begin
      failures++; $display("FAIL fire_idx got=%0d exp=%0d", bus.o_fire_idx, m_last_idx);
    end
    checks++;
    if (bus.o_miss_cnt !== 16'(m_miss)) begin
      failures++; $display("FAIL miss_cnt got=%0d exp=%0d", bus.o_miss_cnt, m_miss);
    end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    checks++;
    if ({bus.o_sync_ready, bus.o_tdc_arm, bus.o_laser_fire} !== '0) begin
      failures++; $display("FAIL reset_ctrl got=%b exp=0", {bus.o_sync_ready, bus.o_tdc_arm, bus.o_laser_fire});
    end
    checks++;
    if ({bus.o_fire_ch, bus.o_fire_idx, bus.o_miss_cnt} !== '0) begin
      failures++; $display("FAIL reset_status got=%h exp=0", {bus.o_fire_ch, bus.o_fire_idx, bus.o_miss_cnt});
    end
    rst_n = 1'b1;
    tick();
    tick();
    checks++;
    if ({bus.o_sync_ready, bus.o_tdc_arm, bus.o_laser_fire} !== '0) begin
      failures++; $display("FAIL idle_ctrl got=%b exp=0", {bus.o_sync_ready, bus.o_tdc_arm, bus.o_laser_fire});
    end
    model_reset();
  endtask

  task automatic test_basic();
    bit f;
    int nf = 0;
    set_cfg(4'b1111, 0, 7);
    start_scan();
    for (int p = 0; p < 10; p++) begin
      run_period(3, -1, -1, f);
      if (f) nf++;
      if (p == 7) begin
        checks++;
        if (bus.o_fire_ch !== 2'd3 || bus.o_fire_idx !== 16'd7) begin
          failures++; $display("FAIL basic_last got=ch%0d/idx%0d exp=ch3/idx7", bus.o_fire_ch, bus.o_fire_idx);
        end
      end
    end
    checks++;
    if (nf != 8) begin
      failures++; $display("FAIL basic_count got=%0d exp=8", nf);
    end
  endtask

  task automatic test_sparse_mask();
    bit f;
    stop_scan();
    set_cfg(4'b1010, 0, 100);
    start_scan();
    for (int p = 0; p < 4; p++) run_period(2, -1, -1, f);
    bus.i_ch_mask = 4'b0001;
    run_period(2, -1, -1, f);
    checks++;
    if (bus.o_fire_ch !== 2'd0) begin
      failures++; $display("FAIL sparse_switch got=%0d exp=0", bus.o_fire_ch);
    end
  endtask

  task automatic test_missed_ack();
    bit f;
    int exp_ch;
    stop_scan();
    set_cfg(4'b1111, 0, 20);
    start_scan();
    for (int p = 0; p < 3; p++) run_period(3, -1, -1, f);
    exp_ch = (m_last_ch + 1) % int'(CH_NUM);
    run_period(-1, -1, -1, f);
    checks++;
    if (f) begin
      failures++; $display("FAIL missed_shot_fired got=1 exp=0");
    end
    run_period(3, -1, -1, f);
    checks++;
    if (bus.o_fire_ch !== CH_W'(exp_ch) || bus.o_fire_idx !== 16'd4) begin
      failures++; $display("FAIL retry got=ch%0d/idx%0d exp=ch%0d/idx4", bus.o_fire_ch, bus.o_fire_idx, exp_ch);
    end
    run_period(ANG, -1, -1, f);
  endtask

  task automatic test_window_edges();
    bit f;
    int nf;
    stop_scan();
    set_cfg(4'b1111, 5, 5);
    start_scan();
    for (int rev = 0; rev < 2; rev++) begin
      nf = 0;
      for (int p = 0; p < 8; p++) begin
        run_period(4, (p == 7) ? 20 : -1, -1, f);
        if (f) nf++;
      end
      checks++;
      if (nf != 1 || bus.o_fire_idx !== 16'd5) begin
        failures++; $display("FAIL win_5_5 rev=%0d got=%0d/idx%0d exp=1/idx5", rev, nf, bus.o_fire_idx);
      end
    end
    set_cfg(4'b1111, 6, 5);
    nf = 0;
    for (int p = 0; p < 8; p++) begin
      run_period(-1, -1, -1, f);
      if (f) nf++;
    end
    checks++;
    if (nf != 0) begin
      failures++; $display("FAIL win_empty got=%0d exp=0", nf);
    end
  endtask

  task automatic test_zero_index();
    bit f;
    stop_scan();
    set_cfg(4'b1111, 3, 4);
    start_scan();
    for (int p = 0; p < 200; p++) run_period(2, -1, -1, f);
    run_period(2, 20, -1, f);
    for (int p = 0; p < 4; p++) run_period(2, -1, -1, f);
    checks++;
    if (bus.o_fire_idx !== 16'd3) begin
      failures++; $display("FAIL zero_restart got=%0d exp=3", bus.o_fire_idx);
    end
    set_cfg(4'b1111, 0, 0);
    run_period(2, ANG, -1, f);
    run_period(2, -1, -1, f);
    checks++;
    if (!f || bus.o_fire_idx !== 16'd0) begin
      failures++; $display("FAIL zero_coincident got=%0d/%0d exp=1/0", f, bus.o_fire_idx);
    end
  endtask

  task automatic test_random();
    bit f;
    int r, ack, z, zc;
    stop_scan();
    set_cfg(4'b1111, 0, 15);
    start_scan();
    for (int p = 0; p < 40; p++) begin
      set_cfg(CH_NUM'($urandom_range(0, 15)), int'($urandom_range(0, 12)), int'($urandom_range(0, 12)));
      r   = int'($urandom_range(0, 9));
      ack = (r < 7) ? int'($urandom_range(1, 8)) : int'($urandom_range(9, 12));
      z   = int'($urandom_range(0, 9));
      zc  = (z == 0) ? ANG : ((z == 1) ? 20 : -1);
      run_period(ack, zc, -1, f);
    end
  endtask

  task automatic test_abort();
    bit f;
    stop_scan();
    set_cfg(4'b1111, 0, 100);
    start_scan();
    run_period(3, -1, ANG + 2, f);
    tick();
    checks++;
    if ({bus.o_sync_ready, bus.o_tdc_arm, bus.o_laser_fire} !== '0) begin
      failures++; $display("FAIL abort_hold got=%b exp=0", {bus.o_sync_ready, bus.o_tdc_arm, bus.o_laser_fire});
    end
    // Re-enable without a zero index: must stay unready (WAIT_ZERO via IDLE).
    bus.i_scan_en = 1'b1;
    repeat (3) tick();
    checks++;
    if (bus.o_sync_ready !== 1'b0) begin
      failures++; $display("FAIL abort_idle got=%b exp=0", bus.o_sync_ready);
    end
  endtask

  task automatic test_async_reset();
    bit f;
    stop_scan();
    set_cfg(4'b1111, 0, 10);
    start_scan();
    bus.i_tdc_strdy = 1'b1;
    tick();
    bus.i_tdc_strdy = 1'b0;
    checks++;
    if (bus.o_tdc_arm !== 1'b1 || bus.o_miss_cnt !== 16'(m_miss)) begin
      failures++; $display("FAIL pre_reset got=arm%b/miss%0d exp=arm1/miss%0d", bus.o_tdc_arm, bus.o_miss_cnt, m_miss);
    end
    tick();
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({bus.o_sync_ready, bus.o_tdc_arm, bus.o_laser_fire} !== '0) begin
      failures++; $display("FAIL async_ctrl got=%b exp=0", {bus.o_sync_ready, bus.o_tdc_arm, bus.o_laser_fire});
    end
    checks++;
    if ({bus.o_fire_ch, bus.o_fire_idx, bus.o_miss_cnt} !== '0) begin
      failures++; $display("FAIL async_status got=%h exp=0", {bus.o_fire_ch, bus.o_fire_idx, bus.o_miss_cnt});
    end
    #3 rst_n = 1'b1;
    model_reset();
    stop_scan();
    set_cfg(4'b1111, 0, 10);
    start_scan();
    run_period(3, -1, -1, f);
    checks++;
    if (!f || bus.o_fire_ch !== 2'd0) begin
      failures++; $display("FAIL post_reset_first got=%0d/ch%0d exp=1/ch0", f, bus.o_fire_ch);
    end
  endtask

  initial begin
    bus.i_scan_en    = 1'b0;
    bus.i_ch_mask    = '0;
    bus.i_start_idx  = '0;
    bus.i_stop_idx   = '0;
    bus.i_zero_sync  = 1'b0;
    bus.i_tdc_strdy  = 1'b0;
    bus.i_angle_sync = 1'b0;
    bus.i_tdc_ack    = 1'b0;
    model_reset();
    test_reset();
    test_basic();
    test_sparse_mask();
    test_missed_ack();
    test_window_edges();
    test_zero_index();
    test_random();
    test_abort();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/opto_emit_scheduler.md
# opto_emit_scheduler

Sequences laser emission for the rotating-mirror scan. It gates the emission-period generator via `o_sync_ready` and uses that generator's `i_tdc_strdy` / `i_angle_sync` ticks to arm the TDC through a ready/ack handshake. It then fires one laser channel per angle tick, chosen round-robin among enabled channels. Firing happens only inside a programmable shot-index window of each revolution. The block sits between the encoder/zero-index logic, the period generator, the TDC front end and the laser drivers.

## Interface
- `CH_NUM`, 4: number of laser channels, 2..8.
- `PULSE_W_CLK`, 5: fire pulse width in clocks, 1..63. Must be smaller than the emission period minus 2.
- `CH_W`, 2: width of `o_fire_ch`; must equal clog2(`CH_NUM`).

- `i_clk` in 1: system clock (100 MHz).
- `i_rst_n` in 1: reset, asynchronous, active-low; clock `i_clk`.
- `i_scan_en` in 1: level; scan run enable.
- `i_ch_mask` in `CH_NUM`: channel enable mask; sampled at arm time.
- `i_start_idx` in 16: first shot index fired, inclusive.
- `i_stop_idx` in 16: last shot index fired, inclusive.
- `i_zero_sync` in 1: one-cycle revolution zero-index pulse.
- `i_tdc_strdy` in 1: one-cycle pre-fire tick, 10 clocks before `i_angle_sync`.
- `i_angle_sync` in 1: one-cycle emission tick.
- `i_tdc_ack` in 1: TDC armed acknowledge.
- `o_sync_ready` out 1: enables the period generator.
- `o_tdc_arm` out 1: TDC arm request, held until ack.
- `o_laser_fire` out `CH_NUM`: one-hot fire pulse.
- `o_fire_ch` out `CH_W`: channel of the last fire.
- `o_fire_idx` out 16: shot index of the last fire.
- `o_miss_cnt` out 16: saturating count of missed shots.

## Operation
- **States:** IDLE, WAIT_ZERO, RUN, WAIT_ACK, WAIT_SYNC, FIRE.
- **IDLE:** all outputs 0. Goes to WAIT_ZERO when `i_scan_en`=1.
- **WAIT_ZERO:** waits for `i_zero_sync`. On it: `shot_idx` := 0, `o_sync_ready` := 1, go to RUN.
- **`o_sync_ready`:** stays 1 in every state except IDLE and WAIT_ZERO.
- **`shot_idx` (16 bit):** clears on each `i_zero_sync` in any non-IDLE state. Increments by 1 on each `i_angle_sync` and saturates at 0xFFFF. If both arrive in the same cycle, the clear wins.
- **Window:** open when `i_start_idx` ≤ `shot_idx` ≤ `i_stop_idx`, evaluated at `i_tdc_strdy`. If `i_start_idx` > `i_stop_idx`, the window is empty.
- **RUN:** on `i_tdc_strdy` with the window open and `i_ch_mask`≠0:
  - latch the next channel: the lowest set mask bit strictly above `rr_ptr`, wrapping to bit 0;
  - assert `o_tdc_arm`;
  - go to WAIT_ACK.
  - Otherwise stay in RUN; `i_angle_sync` then only increments the index.
- **WAIT_ACK:**
  - `i_tdc_ack`=1 → drop `o_tdc_arm`, go to WAIT_SYNC.
  - `i_angle_sync` before the ack (same-cycle ack counts as late) → miss: drop arm, `o_miss_cnt`+1 (saturating at 0xFFFF), `rr_ptr` unchanged so the same channel retries, go to RUN.
- **WAIT_SYNC:** on `i_angle_sync`:
  - `o_laser_fire[ch]` := 1;
  - `o_fire_ch` := ch; `o_fire_idx` := `shot_idx` before its increment;
  - `rr_ptr` := ch;
  - go to FIRE.
- **FIRE:** holds the pulse for exactly `PULSE_W_CLK` cycles, then returns to RUN. An `i_tdc_strdy` during FIRE is ignored; that shot is skipped and not counted as a miss.
- **`i_scan_en`=0 in any state:** go to IDLE next cycle and clear arm, fire and `o_sync_ready`. An in-flight pulse is truncated. `o_fire_*` and `o_miss_cnt` hold their values.
- **Reset values:** `rr_ptr` = `CH_NUM`-1, so the first pick is channel 0. All outputs 0.

## Timing
- All outputs are registered.
- `i_tdc_strdy` at cycle t → `o_tdc_arm` high at t+1.
- `i_tdc_ack` at cycle a → `o_tdc_arm` low at a+1.
- `i_angle_sync` at cycle s → `o_laser_fire` high for cycles s+1 .. s+`PULSE_W_CLK`. `o_fire_ch` and `o_fire_idx` update at s+1.
- `i_zero_sync` at z in WAIT_ZERO → `o_sync_ready` high at z+1.
- `i_scan_en` falling at f → all fire/arm/ready outputs low at f+1.
- Async reset clears the state immediately, mid-pulse included.
- Throughput: one fire per emission period (125 clocks at 800 kHz / 100 MHz).

## Test plan
- **Basic sequence:** mask=4'b1111, window 0..7, ack 2 clocks after arm, zero_sync then 10 periods → fires ch0,1,2,3,0,1,2,3 at idx 0..7, none at idx 8,9; each pulse 5 clocks wide, starting 1 clock after its angle_sync.
- **Sparse mask:** mask=4'b1010 → fire order ch1,ch3,ch1,… Change mask to 4'b0001 mid-run → the next arm picks ch0.
- **Missed ack:** ack withheld for shot idx 3 → no fire at idx 3, `o_miss_cnt`=1, idx 4 fires the same channel idx 3 would have used.
- **Window edges:** start=5, stop=5 → exactly one fire per revolution, `o_fire_idx`=5. Start=6, stop=5 → zero fires and `o_miss_cnt` stays 0.
- **Zero-index reset:** zero_sync at idx 200 → index restarts at 0 and firing resumes at `i_start_idx` of the new revolution. Zero_sync coincident with angle_sync → `shot_idx`=0.
- **Abort and reset:** drop `i_scan_en` at pulse cycle 2 → fire low next clock, `o_sync_ready` low, state IDLE. Assert `i_rst_n`=0 mid-WAIT_ACK → all outputs 0 asynchronously and `o_miss_cnt`=0.
